// File: rtl/kernel_cpu_cpu_pkg.sv
// Shared widths and types for the CPU multiplier datapath.
// Partial products are 32 bits; the cross terms contribute only their low half-words.
package kernel_cpu_cpu_pkg;

    localparam int unsigned DST_W_DEF = 5;
    localparam int unsigned HALF_W    = 16;
    localparam int unsigned PP_W      = 32;

    typedef logic [HALF_W-1:0] half_t;
    typedef logic [PP_W-1:0]   pp_t;

    // Partial products presented by the mult cell while an instruction sits in M.
    typedef struct packed {
        pp_t p1;
        pp_t p2;
        pp_t p3;
    } pp_bus_t;

    // Place a half-word in the upper half of a partial-product-wide word.
    function automatic pp_t shift_half(input half_t h);
        return PP_W'({h, {HALF_W{1'b0}}});
    endfunction

endpackage

// File: rtl/kernel_cpu_cpu_mult_combine_if.sv
// Pipeline-side bus of the multiply combine stage.
// The master side is the pipeline and mult cell; the slave side is the combine block.
interface kernel_cpu_cpu_mult_combine_if
    import kernel_cpu_cpu_pkg::*;
#(
    parameter int unsigned DST_W = DST_W_DEF
);
    logic             E_mul_valid;
    logic [DST_W-1:0] E_mul_dst;
    logic             M_en;
    logic             M_flush;
    pp_t              M_mul_cell_p1;
    pp_t              M_mul_cell_p2;
    pp_t              M_mul_cell_p3;
    pp_t              W_mul_result;
    logic             W_mul_valid;
    logic [DST_W-1:0] W_mul_dst;
    logic             mul_busy;

    modport master (
        output E_mul_valid, E_mul_dst, M_en, M_flush,
               M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
        input  W_mul_result, W_mul_valid, W_mul_dst, mul_busy
    );

    modport slave (
        input  E_mul_valid, E_mul_dst, M_en, M_flush,
               M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
        output W_mul_result, W_mul_valid, W_mul_dst, mul_busy
    );

endinterface

// File: rtl/kernel_cpu_cpu_mult_sum.sv
// Combines the three partial products into the low 32 bits of the product.
// Upper halves of the cross terms and every carry above bit 31 fall away.
module kernel_cpu_cpu_mult_sum
    import kernel_cpu_cpu_pkg::*;
(
    input  pp_bus_t pp,
    output pp_t     comb_c
);

    half_t cross_c;
    logic  unused_hi;

    // Cross-term high halves only affect bits above 31.
    assign unused_hi = ^{pp.p2[PP_W-1:HALF_W], pp.p3[PP_W-1:HALF_W]};

    assign cross_c = pp.p2[HALF_W-1:0] + pp.p3[HALF_W-1:0];
    assign comb_c  = pp.p1 + shift_half(cross_c);

endmodule

// File: rtl/kernel_cpu_cpu_mult_combine.sv
// M/W pipeline registers around the multiply partial-product combiner.
// A multiply sampled in E lands in W two enabled edges later.
module kernel_cpu_cpu_mult_combine
    import kernel_cpu_cpu_pkg::*;
#(
    parameter int unsigned DST_W = DST_W_DEF
)(
    input  logic                         clk,
    input  logic                         reset,
    kernel_cpu_cpu_mult_combine_if.slave bus
);

    logic             m_pend;
    logic [DST_W-1:0] m_dst;
    logic             w_valid;
    logic [DST_W-1:0] w_dst;
    pp_t              w_result;
    pp_bus_t          pp_c;
    pp_t              comb_c;

    assign pp_c = '{p1: bus.M_mul_cell_p1, p2: bus.M_mul_cell_p2, p3: bus.M_mul_cell_p3};

    kernel_cpu_cpu_mult_sum u_sum (
        .pp     (pp_c),
        .comb_c (comb_c)
    );

    // A flush during a stall only kills the M-stage instruction; W keeps its result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend   <= 1'b0;
            m_dst    <= '0;
            w_valid  <= 1'b0;
            w_dst    <= '0;
            w_result <= '0;
        end else if (bus.M_en) begin
            m_pend   <= bus.E_mul_valid;
            m_dst    <= bus.E_mul_dst;
            w_valid  <= m_pend & ~bus.M_flush;
            w_dst    <= m_dst;
            w_result <= comb_c;
        end else if (bus.M_flush) begin
            m_pend   <= 1'b0;
        end
    end

    assign bus.W_mul_valid  = w_valid;
    assign bus.W_mul_dst    = w_dst;
    assign bus.W_mul_result = w_result;
    assign bus.mul_busy     = m_pend;

endmodule

// File: tb/tb_kernel_cpu_cpu_mult_combine.sv
// Bench for the multiply combine stage: table-driven stream plus stall, flush and reset sequences.
// Each sampled multiply carries its partial products and expected result through a queue.
module tb_kernel_cpu_cpu_mult_combine;

    localparam int unsigned DW = 5;
    localparam int unsigned NV = 6;

    typedef struct {
        logic [DW-1:0] dst;
        logic [31:0]   p1;
        logic [31:0]   p2;
        logic [31:0]   p3;
        logic [31:0]   exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    kernel_cpu_cpu_mult_combine_if #(.DST_W(DW)) bus ();

    kernel_cpu_cpu_mult_combine #(.DST_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   applied    = 0;
    int   miscompares = 0;
    vec_t q[$];
    vec_t tbl[NV];
    vec_t nil;
    vec_t w_exp;
    logic w_exp_valid;

    function automatic vec_t mk(input logic [DW-1:0] dst, input logic [31:0] p1,
                                input logic [31:0] p2, input logic [31:0] p3,
                                input logic [31:0] exp);
        vec_t v;
        v.dst = dst; v.p1 = p1; v.p2 = p2; v.p3 = p3; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic check_outputs();
        check("w_valid", 32'(bus.W_mul_valid), 32'(w_exp_valid));
        if (w_exp_valid) begin
            check("w_result", bus.W_mul_result, w_exp.exp);
            check("w_dst", 32'(bus.W_mul_dst), 32'(w_exp.dst));
        end
        check("mul_busy", 32'(bus.mul_busy), 32'(q.size() != 0));
    endtask

    task automatic check_zero();
        check("rst_valid", 32'(bus.W_mul_valid), 32'h0);
        check("rst_dst", 32'(bus.W_mul_dst), 32'h0);
        check("rst_result", bus.W_mul_result, 32'h0);
        check("rst_busy", 32'(bus.mul_busy), 32'h0);
    endtask

    // One clock: drive E/M inputs, partial products of the queued M instruction, then check W.
    task automatic cyc(input logic en, input logic ev, input logic flush, input vec_t v);
        vec_t it;
        bus.E_mul_valid = ev;
        bus.E_mul_dst   = v.dst;
        bus.M_en        = en;
        bus.M_flush     = flush;
        if (q.size() != 0) begin
            bus.M_mul_cell_p1 = q[0].p1;
            bus.M_mul_cell_p2 = q[0].p2;
            bus.M_mul_cell_p3 = q[0].p3;
        end else begin
            bus.M_mul_cell_p1 = 32'h0;
            bus.M_mul_cell_p2 = 32'h0;
            bus.M_mul_cell_p3 = 32'h0;
        end
        @(posedge clk);
        #1;
        if (en) begin
            if (q.size() != 0) begin
                it          = q.pop_front();
                w_exp_valid = !flush;
                w_exp       = it;
            end else begin
                w_exp_valid = 1'b0;
            end
            if (ev) q.push_back(v);
        end else if (flush && q.size() != 0) begin
            void'(q.pop_front());
        end
        check_outputs();
    endtask

    initial begin
        nil    = mk(5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        tbl[0] = mk(5'd7,  32'd15,        32'h0,        32'h0,        32'h0000000F);
        tbl[1] = mk(5'd3,  32'd8,         32'd6,        32'd4,        32'h000A0008);
        tbl[2] = mk(5'd31, 32'hFFFE0001,  32'hFFFE0001, 32'hFFFE0001, 32'h00000001);
        tbl[3] = mk(5'd12, 32'h12345678,  32'h0000FFFF, 32'h00000001, 32'h12345678);
        tbl[4] = mk(5'd1,  32'h00000000,  32'hABCD1234, 32'h56780001, 32'h12350000);
        tbl[5] = mk(5'd20, 32'hFFFF0000,  32'h00000001, 32'h00000000, 32'h00000000);

        reset           = 1'b1;
        bus.E_mul_valid = 1'b0;
        bus.E_mul_dst   = '0;
        bus.M_en        = 1'b0;
        bus.M_flush     = 1'b0;
        bus.M_mul_cell_p1 = 32'h0;
        bus.M_mul_cell_p2 = 32'h0;
        bus.M_mul_cell_p3 = 32'h0;
        w_exp_valid     = 1'b0;
        w_exp           = nil;
        repeat (2) @(posedge clk);
        #1;
        check_zero();
        reset = 1'b0;

        // Back-to-back stream: one result per enabled edge
        for (int e = 0; e <= int'(NV); e++)
            cyc(1'b1, e < int'(NV), 1'b0, (e < int'(NV)) ? tbl[e] : nil);

        // Stall with a multiply in M, then a stall with a valid result in W
        cyc(1'b1, 1'b1, 1'b0, tbl[1]);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, nil);
        cyc(1'b1, 1'b0, 1'b0, nil);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, nil);

        // Enabled flush kills M but samples the new E instruction
        cyc(1'b1, 1'b1, 1'b0, tbl[2]);
        cyc(1'b1, 1'b1, 1'b1, tbl[3]);
        cyc(1'b1, 1'b0, 1'b0, nil);

        // Flush during a stall clears M only; W holds
        cyc(1'b1, 1'b1, 1'b0, tbl[4]);
        cyc(1'b1, 1'b1, 1'b0, tbl[5]);
        cyc(1'b0, 1'b0, 1'b1, nil);
        cyc(1'b1, 1'b0, 1'b0, nil);

        // Asynchronous reset with work in both M and W
        cyc(1'b1, 1'b1, 1'b0, tbl[0]);
        cyc(1'b1, 1'b1, 1'b0, tbl[2]);
        reset = 1'b1;
        #2;
        check_zero();
        q.delete();
        w_exp_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, nil);
        cyc(1'b1, 1'b1, 1'b0, tbl[1]);
        cyc(1'b1, 1'b0, 1'b0, nil);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
